// File: rtl/counter_load_seq.sv
// rtl/counter_load_seq.sv - FIFO-fed sequencer driving a loadable match counter's data/load/en.
module counter_load_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     run,
  input  logic                     match_n,
  output logic                     en,
  output logic [WIDTH-1:0]         data,
  output logic                     load,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_LOAD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push;
  logic             pop;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             underrun_q, underrun_d;

  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    underrun_d = underrun_q;
    case (state_q)
      S_IDLE: begin
        if (run && (level_q != '0)) begin
          state_d = S_PREP;
          pop     = 1'b1;
        end
      end
      S_PREP: state_d = S_LOAD;
      // A run drop during PREP/LOAD lets the load finish, then parks in IDLE.
      S_LOAD: state_d = run ? S_RUN : S_IDLE;
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (!match_n) begin
          if (level_q != '0) begin
            state_d = S_PREP;
            pop     = 1'b1;
          end else begin
            state_d    = S_IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies are glitch-free.
    en_d   = (state_d == S_RUN);
    load_d = (state_d == S_LOAD);
    data_d = pop ? mem_q[rd_ptr_q] : data_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Storage is not reset; clearing the pointers and level discards its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      load_q     <= load_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign en       = en_q;
  assign load     = load_q;
  assign data     = data_q;
  assign level    = level_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_counter_load_seq.sv
// tb/tb_counter_load_seq.sv - directed self-checking bench for counter_load_seq.
module tb_counter_load_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic       run = 1'b0;
  logic       match_n = 1'b1;
  logic       en;
  logic [3:0] data;
  logic       load;
  logic [2:0] level;
  logic       underrun;

  int tests = 0;
  int fails = 0;

  counter_load_seq #(.WIDTH(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .run      (run),
    .match_n  (match_n),
    .en       (en),
    .data     (data),
    .load     (load),
    .level    (level),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst && load && en) begin
      tests++;
      fails++;
      $error("FAIL load_en_overlap: observed load=1 en=1 expected not both high");
    end
  end

  initial begin
    #2 rst = 1'b0;
    step();
    step();
    check("rst_hold_en", en, 0);
    check("rst_hold_level", level, 0);
    rst = 1'b1;
    step();
    check("idle_en", en, 0);
    check("idle_load", load, 0);
    check("idle_data", data, 0);
    check("idle_level", level, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_underrun", underrun, 0);

    // Single load of 9.
    run = 1'b1; in_valid = 1'b1; in_data = 4'd9;
    step();
    in_valid = 1'b0;
    check("e0_level", level, 1);
    check("e0_load", load, 0);
    step();
    check("e1_data", data, 9);
    check("e1_level", level, 0);
    check("e1_load", load, 0);
    check("e1_en", en, 0);
    step();
    check("e2_load", load, 1);
    check("e2_en", en, 0);
    check("e2_data", data, 9);
    step();
    check("e3_load", load, 0);
    check("e3_en", en, 1);
    step();
    check("run_hold_en", en, 1);
    run = 1'b0;
    step();
    check("rundrop_en", en, 0);

    // Chained 3, 5, 7.
    in_valid = 1'b1;
    in_data = 4'd3; step();
    in_data = 4'd5; step();
    in_data = 4'd7; step();
    in_valid = 1'b0;
    check("chain_level3", level, 3);
    run = 1'b1;
    step();
    check("chain1_data", data, 3);
    check("chain1_level", level, 2);
    step();
    check("chain1_load", load, 1);
    step();
    check("chain1_en", en, 1);
    match_n = 1'b0;
    step();
    match_n = 1'b1;
    check("chain2_en_gap", en, 0);
    check("chain2_data", data, 5);
    check("chain2_level", level, 1);
    step();
    check("chain2_load", load, 1);
    check("chain2_load_en", en, 0);
    step();
    check("chain2_en", en, 1);
    match_n = 1'b0;
    step();
    match_n = 1'b1;
    check("chain3_data", data, 7);
    check("chain3_level", level, 0);
    check("chain3_en_gap", en, 0);
    step();
    check("chain3_load", load, 1);
    step();
    check("chain3_en", en, 1);
    check("chain3_no_underrun", underrun, 0);
    match_n = 1'b0;
    step();
    match_n = 1'b1;
    check("underrun_set", underrun, 1);
    check("underrun_en", en, 0);
    check("underrun_load", load, 0);
    step();
    check("underrun_idle_en", en, 0);
    check("underrun_idle_load", load, 0);
    check("underrun_data_hold", data, 7);

    // Full FIFO with run low.
    run = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd1; step();
    in_data = 4'd2; step();
    in_data = 4'd3; step();
    in_data = 4'd4; step();
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    in_data = 4'hF;
    step();
    check("full_reject_level", level, 4);
    check("underrun_sticky", underrun, 1);
    run = 1'b1;
    step();
    in_valid = 1'b0;
    check("full_pop_data", data, 1);
    check("full_pop_level", level, 3);
    check("full_pop_in_ready", in_ready, 1);
    step();
    check("full_load", load, 1);
    step();
    check("full_en", en, 1);
    match_n = 1'b0; in_valid = 1'b1; in_data = 4'hA;
    step();
    match_n = 1'b1; in_valid = 1'b0;
    check("pushpop_level", level, 3);
    check("pushpop_data", data, 2);
    step(); step();
    match_n = 1'b0;
    step();
    match_n = 1'b1;
    check("order_data3", data, 3);
    check("order_level2", level, 2);
    step(); step();
    match_n = 1'b0;
    step();
    match_n = 1'b1;
    check("order_data4", data, 4);
    step(); step();
    match_n = 1'b0;
    step();
    match_n = 1'b1;
    check("order_dataA", data, 4'hA);
    check("order_level0", level, 0);
    step(); step();
    check("order_en", en, 1);

    // Run drop during LOAD, with match_n low to show it is ignored there.
    run = 1'b0;
    step();
    check("drop_idle_en", en, 0);
    in_valid = 1'b1;
    in_data = 4'd6; step();
    in_data = 4'd8; step();
    in_valid = 1'b0;
    check("drop_level2", level, 2);
    run = 1'b1;
    step();
    check("drop_prep_data", data, 6);
    step();
    check("drop_load", load, 1);
    run = 1'b0; match_n = 1'b0;
    step();
    check("drop_after_load", load, 0);
    check("drop_after_en", en, 0);
    check("drop_after_data", data, 6);
    check("drop_after_level", level, 1);
    step();
    match_n = 1'b1;
    check("drop_idle2_en", en, 0);
    check("drop_no_pop", level, 1);

    // Asynchronous reset while load is high.
    run = 1'b1;
    step();
    check("ar_prep_data", data, 8);
    in_valid = 1'b1; in_data = 4'd2;
    step();
    in_valid = 1'b0;
    check("ar_load_high", load, 1);
    check("ar_level1", level, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_load", load, 0);
    check("ar_en", en, 0);
    check("ar_level", level, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_data", data, 0);
    check("ar_underrun", underrun, 0);
    rst = 1'b1;
    run = 1'b0;
    step();
    check("ar_post_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
